muon_coinc_trigger: RTL

//  Front-end trigger stage feeding the EosMuon top: takes raw scintillator discriminator lines from PIN-IO planes A and B.

---
 rtl/muon_coinc_trigger.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/muon_coinc_trigger.sv
// A*B plane coincidence trigger: sync, edge detect, per-plane windows, pulse/dead FSM, hit-pattern latch.
// Optional singles scalers are compiled in when MUON_SCALER_EN is defined; otherwise singles_a/b read 0.
module muon_coinc_trigger #(
  parameter int NCH   = 24,
  parameter int WIN   = 4,
  parameter int PULSE = 5,
  parameter int DEAD  = 50,
  parameter int CNT_W = 32
) (
  input  logic             Clk50,
  input  logic             Rst_n,
  input  logic [NCH-1:0]   ch_a,
  input  logic [NCH-1:0]   ch_b,
  input  logic             trig_en,
  output logic             trig_out,
  output logic             busy,
  output logic [CNT_W-1:0] trig_count,
  output logic [NCH-1:0]   hit_pat_a,
  output logic [NCH-1:0]   hit_pat_b,
  output logic             pat_valid,
  input  logic             pat_ack,
  output logic             pat_ovf,
  output logic [CNT_W-1:0] singles_a,
  output logic [CNT_W-1:0] singles_b
);

  localparam int WW   = $clog2(WIN + 1);
  localparam int TMAX = (PULSE > DEAD) ? PULSE : DEAD;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_DEAD} state_t;

  state_t               state_reg, state_next;
  logic [TW-1:0]        tmr_reg, tmr_next;
  logic [1:0]           mask_cnt_reg;
  logic                 mask_done;
  logic [2*NCH-1:0]     ch_all;
  logic [2*NCH-1:0]     edge_all;
  logic [1:0]           act;
  logic [1:0][NCH-1:0]  pat_now;
  logic [1:0][CNT_W-1:0] singles_cnt;
  logic                 fire;
  logic                 clr_win;

  logic                 trig_out_reg, busy_reg;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [NCH-1:0]       pat_a_reg, pat_a_next, pat_b_reg, pat_b_next;
  logic                 valid_reg, valid_next, ovf_reg, ovf_next;

  assign ch_all    = {ch_b, ch_a};
  assign mask_done = (mask_cnt_reg == 2'd3);

  // Edges are suppressed until three clocks after reset release so lines high at release never fire.
  always_ff @(posedge Clk50 or negedge Rst_n) begin
    if (!Rst_n)
      mask_cnt_reg <= 2'd0;
    else if (!mask_done)
      mask_cnt_reg <= mask_cnt_reg + 2'd1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2 * NCH; gi++) begin : g_sync
      logic s1_reg, s2_reg, prev_reg, edge_reg;
      always_ff @(posedge Clk50 or negedge Rst_n) begin
        if (!Rst_n) begin
          s1_reg   <= 1'b0;
          s2_reg   <= 1'b0;
          prev_reg <= 1'b0;
          edge_reg <= 1'b0;
        end else begin
          s1_reg   <= ch_all[gi];
          s2_reg   <= s1_reg;
          prev_reg <= s2_reg;
          edge_reg <= mask_done & s2_reg & ~prev_reg;
        end
      end
      assign edge_all[gi] = edge_reg;
    end

    for (gi = 0; gi < 2; gi++) begin : g_plane
      logic [NCH-1:0] edg;
      logic [WW-1:0]  win_reg, win_next;
      logic [NCH-1:0] acc_reg, acc_next, acc_eff;

      assign edg     = edge_all[gi*NCH +: NCH];
      // Accumulator content from an already expired window must not leak into a new one.
      assign acc_eff = (win_reg != '0) ? acc_reg : '0;
      assign act[gi] = (|edg) | (win_reg != '0);
      assign pat_now[gi] = acc_eff | edg;

      always_comb begin
        win_next = win_reg;
        acc_next = '0;
        if (clr_win) begin
          win_next = '0;
        end else if (|edg) begin
          win_next = WW'(WIN - 1);
          acc_next = acc_eff | edg;
        end else if (win_reg != '0) begin
          win_next = win_reg - WW'(1);
          acc_next = acc_reg;
        end
      end

      always_ff @(posedge Clk50 or negedge Rst_n) begin
        if (!Rst_n) begin
          win_reg <= '0;
          acc_reg <= '0;
        end else begin
          win_reg <= win_next;
          acc_reg <= acc_next;
        end
      end

`ifdef MUON_SCALER_EN
      logic [CNT_W-1:0] sgl_reg;
      always_ff @(posedge Clk50 or negedge Rst_n) begin
        if (!Rst_n)
          sgl_reg <= '0;
        else if (|edg)
          sgl_reg <= sgl_reg + CNT_W'(1);
      end
      assign singles_cnt[gi] = sgl_reg;
`else
      assign singles_cnt[gi] = '0;
`endif
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    tmr_next   = tmr_reg;
    fire       = 1'b0;
    clr_win    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (trig_en && act[0] && act[1]) begin
          fire       = 1'b1;
          state_next = ST_PULSE;
          tmr_next   = TW'(PULSE - 1);
        end
      end
      ST_PULSE: begin
        if (tmr_reg == '0) begin
          clr_win = 1'b1;
          if (DEAD == 0) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DEAD;
            tmr_next   = TW'(DEAD - 1);
          end
        end else begin
          tmr_next = tmr_reg - TW'(1);
        end
      end
      ST_DEAD: begin
        if (tmr_reg == '0)
          state_next = ST_IDLE;
        else
          tmr_next = tmr_reg - TW'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A same-cycle ack frees the latch, so the new trigger pattern wins over the consume.
  always_comb begin
    cnt_next   = cnt_reg;
    pat_a_next = pat_a_reg;
    pat_b_next = pat_b_reg;
    valid_next = valid_reg;
    ovf_next   = ovf_reg;
    if (fire) begin
      cnt_next = cnt_reg + CNT_W'(1);
      if (!valid_reg || pat_ack) begin
        pat_a_next = pat_now[0];
        pat_b_next = pat_now[1];
        valid_next = 1'b1;
        ovf_next   = 1'b0;
      end else begin
        ovf_next = 1'b1;
      end
    end else if (pat_ack && valid_reg) begin
      valid_next = 1'b0;
      ovf_next   = 1'b0;
    end
  end

  always_ff @(posedge Clk50 or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= ST_IDLE;
      tmr_reg      <= '0;
      trig_out_reg <= 1'b0;
      busy_reg     <= 1'b0;
      cnt_reg      <= '0;
      pat_a_reg    <= '0;
      pat_b_reg    <= '0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tmr_reg      <= tmr_next;
      trig_out_reg <= (state_next == ST_PULSE);
      busy_reg     <= (state_next != ST_IDLE);
      cnt_reg      <= cnt_next;
      pat_a_reg    <= pat_a_next;
      pat_b_reg    <= pat_b_next;
      valid_reg    <= valid_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign trig_out   = trig_out_reg;
  assign busy       = busy_reg;
  assign trig_count = cnt_reg;
  assign hit_pat_a  = pat_a_reg;
  assign hit_pat_b  = pat_b_reg;
  assign pat_valid  = valid_reg;
  assign pat_ovf    = ovf_reg;
  assign singles_a  = singles_cnt[0];
  assign singles_b  = singles_cnt[1];

endmodule
